// File: rtl/subarray_mac_seq.sv
// Bit-serial shift-add multiply-accumulate sequencer: one multiplier bit per cycle,
// VEC_LEN products summed into a dot product presented over a valid/ready port.
module subarray_mac_seq #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ACC_W   = 24,
    parameter int unsigned VEC_LEN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf,
    output logic              busy
);

    localparam int unsigned BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned EC_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int unsigned P_W  = 2 * DATA_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ACC  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [P_W-1:0]    r_prod;
    logic [P_W-1:0]    w_addend;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [EC_W-1:0]   r_elem_cnt;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W:0]    w_acc_sum;
    logic              r_ovf;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_last_bit;
    logic              w_last_elem;

    always_comb begin
        w_in_fire   = r_in_ready & in_valid & ~clr;
        w_out_fire  = r_out_valid & out_ready & ~clr;
        w_last_bit  = (r_bit_cnt == BC_W'(DATA_W - 1));
        w_last_elem = (r_elem_cnt == EC_W'(VEC_LEN - 1));
        w_addend    = r_b[r_bit_cnt] ? (P_W'(r_a) << r_bit_cnt) : '0;
        w_acc_sum   = {1'b0, r_acc} + (ACC_W + 1)'(r_prod);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_in_fire) w_next = S_MUL;
            S_MUL:   if (w_last_bit) w_next = S_ACC;
            S_ACC:   w_next = w_last_elem ? S_OUT : S_IDLE;
            S_OUT:   if (w_out_fire) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (clr) w_next = S_IDLE;
    end

    // Handshake/status flags are registered from the next state so they read 0 during
    // reset and come up with in_ready=1 on the first cycle after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next == S_IDLE);
            r_out_valid <= (w_next == S_OUT);
            r_busy      <= (w_next != S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_prod     <= '0;
            r_bit_cnt  <= '0;
            r_elem_cnt <= '0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
        end else if (clr) begin
            r_prod     <= '0;
            r_bit_cnt  <= '0;
            r_elem_cnt <= '0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_fire) begin
                        r_a       <= in_a;
                        r_b       <= in_b;
                        r_prod    <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                S_MUL: begin
                    r_prod    <= r_prod + w_addend;
                    r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
                end
                S_ACC: begin
                    r_acc      <= w_acc_sum[ACC_W-1:0];
                    r_ovf      <= r_ovf | w_acc_sum[ACC_W];
                    r_elem_cnt <= w_last_elem ? '0 : r_elem_cnt + 1'b1;
                end
                S_OUT: begin
                    if (w_out_fire) begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_acc   = r_acc;
    assign out_ovf   = r_ovf;
    assign busy      = r_busy;

endmodule

// File: tb/tb_subarray_mac_seq.sv
// Self-checking bench for subarray_mac_seq: directed scenarios plus random vectors on a
// 24-bit/4-element instance and a 16-bit/2-element instance, against an arithmetic model.
module tb_subarray_mac_seq;

    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    int         sel;

    logic        rdy0, vld0, ovf0, busy0;
    logic        rdy1, vld1, ovf1, busy1;
    logic [23:0] acc0;
    logic [15:0] acc1;

    logic        in_ready, out_valid, out_ovf, busy;
    logic [23:0] out_acc;

    int      n_cmp = 0;
    int      n_bad = 0;
    longint  m_acc[2];
    bit      m_ovf[2];

    always #5 clk = ~clk;

    subarray_mac_seq #(.DATA_W(8), .ACC_W(24), .VEC_LEN(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr && sel == 0),
        .in_valid(in_valid && sel == 0), .in_ready(rdy0),
        .in_a(in_a), .in_b(in_b),
        .out_valid(vld0), .out_ready(out_ready && sel == 0),
        .out_acc(acc0), .out_ovf(ovf0), .busy(busy0)
    );

    subarray_mac_seq #(.DATA_W(8), .ACC_W(16), .VEC_LEN(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr && sel == 1),
        .in_valid(in_valid && sel == 1), .in_ready(rdy1),
        .in_a(in_a), .in_b(in_b),
        .out_valid(vld1), .out_ready(out_ready && sel == 1),
        .out_acc(acc1), .out_ovf(ovf1), .busy(busy1)
    );

    assign in_ready  = (sel == 1) ? rdy1 : rdy0;
    assign out_valid = (sel == 1) ? vld1 : vld0;
    assign out_ovf   = (sel == 1) ? ovf1 : ovf0;
    assign busy      = (sel == 1) ? busy1 : busy0;
    assign out_acc   = (sel == 1) ? {8'b0, acc1} : acc0;

    function automatic int vlen(input int s);
        return (s == 1) ? 2 : 4;
    endfunction

    function automatic int accw(input int s);
        return (s == 1) ? 16 : 24;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input int s);
        m_acc[s] = 0;
        m_ovf[s] = 1'b0;
    endtask

    // Reference: exact product added to the running sum; ovf when the sum leaves ACC_W bits.
    task automatic model_add(input int s, input logic [7:0] a, input logic [7:0] b);
        longint sum;
        sum = m_acc[s] + longint'(a) * longint'(b);
        if (sum >= (64'sd1 <<< accw(s))) m_ovf[s] = 1'b1;
        m_acc[s] = sum % (64'sd1 <<< accw(s));
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        chk("accept_ready", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic accept(input logic [7:0] a, input logic [7:0] b);
        wait_ready();
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        step();
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        model_add(sel, a, b);
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit last);
        int n;
        accept(a, b);
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
        chk("ready_after_accept", {31'b0, in_ready}, 32'd0);
        n = 0;
        while (!(in_ready || out_valid) && n < 40) begin
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            step();
            n++;
        end
        chk("elem_latency", n, DW + 1);
        if (last) chk("out_valid_rise", {31'b0, out_valid}, 32'd1);
        else      chk("ready_reassert", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic take_result(input int hold);
        logic [23:0] held;
        chk("out_valid", {31'b0, out_valid}, 32'd1);
        chk("out_acc", {8'b0, out_acc}, 32'(m_acc[sel]));
        chk("out_ovf", {31'b0, out_ovf}, {31'b0, m_ovf[sel]});
        held = out_acc;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_acc", {8'b0, out_acc}, {8'b0, held});
            chk("hold_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_consume_ready", {31'b0, in_ready}, 32'd1);
        chk("post_consume_valid", {31'b0, out_valid}, 32'd0);
        chk("post_consume_busy", {31'b0, busy}, 32'd0);
        model_clear(sel);
    endtask

    task automatic run_ones(input logic [7:0] a, input logic [7:0] b);
        for (int e = 0; e < vlen(sel); e++) send(a, b, e == vlen(sel) - 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 0;
        rst_n = 1'b0;
        clr = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        model_clear(0);
        model_clear(1);

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'($urandom);
            clr       = 1'($urandom);
            out_ready = 1'($urandom);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            step();
        end
        chk("rst_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_acc", {8'b0, out_acc}, 32'd0);
        chk("rst_ovf", {31'b0, out_ovf}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        in_valid = 1'b0;
        clr = 1'b0;
        out_ready = 1'b0;
        #4 rst_n = 1'b1;
        step();
        chk("rel_ready", {31'b0, in_ready}, 32'd1);
        chk("rel_busy", {31'b0, busy}, 32'd0);

        // Basic dot product then backpressure
        send(8'd3, 8'd5, 1'b0);
        send(8'd255, 8'd255, 1'b0);
        send(8'd0, 8'd200, 1'b0);
        send(8'd16, 8'd16, 1'b1);
        chk("s2_acc_const", {8'b0, out_acc}, 32'd65296);
        chk("s2_ovf_const", {31'b0, out_ovf}, 32'd0);
        take_result(7);
        run_ones(8'd1, 8'd1);
        chk("s4_restart_const", {8'b0, out_acc}, 32'd4);
        take_result(0);

        // Overflow on the 16-bit / 2-element instance
        sel = 1;
        step();
        run_ones(8'd255, 8'd255);
        chk("s3_acc_const", {8'b0, out_acc}, 32'd64514);
        chk("s3_ovf_const", {31'b0, out_ovf}, 32'd1);
        take_result(1);
        run_ones(8'd1, 8'd1);
        chk("s3b_acc_const", {8'b0, out_acc}, 32'd2);
        chk("s3b_ovf_const", {31'b0, out_ovf}, 32'd0);
        take_result(0);

        // Random vectors on both instances
        for (int s = 1; s >= 0; s--) begin
            sel = s;
            step();
            for (int v = 0; v < 4; v++) begin
                for (int e = 0; e < vlen(s); e++)
                    send(8'($urandom_range(128, 255)), 8'($urandom), e == vlen(s) - 1);
                take_result(int'($urandom_range(0, 3)));
            end
        end

        // clr during the 4th element's MUL
        sel = 0;
        for (int e = 0; e < 3; e++) send(8'd255, 8'd255, 1'b0);
        accept(8'd255, 8'd255);
        step();
        step();
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        model_clear(0);
        chk("clr_ready", {31'b0, in_ready}, 32'd1);
        chk("clr_busy", {31'b0, busy}, 32'd0);
        chk("clr_acc", {8'b0, out_acc}, 32'd0);
        chk("clr_valid", {31'b0, out_valid}, 32'd0);
        // clr coincident with a handshake in IDLE drops the operand
        in_valid = 1'b1;
        clr = 1'b1;
        in_a = 8'd9;
        in_b = 8'd9;
        step();
        in_valid = 1'b0;
        clr = 1'b0;
        chk("clr_hs_ready", {31'b0, in_ready}, 32'd1);
        chk("clr_hs_busy", {31'b0, busy}, 32'd0);
        run_ones(8'd1, 8'd1);
        chk("clr_then_ones", {8'b0, out_acc}, 32'd4);
        take_result(0);

        // Async reset while in ACC
        send(8'd5, 8'd7, 1'b0);
        accept(8'd9, 8'd9);
        for (int i = 0; i < DW; i++) step();
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        chk("pre_rst_acc", {8'b0, out_acc}, 32'd35);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", {31'b0, in_ready}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_acc", {8'b0, out_acc}, 32'd0);
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_ovf", {31'b0, out_ovf}, 32'd0);
        model_clear(0);
        model_clear(1);
        #3 rst_n = 1'b1;
        step();
        chk("arst_rel_ready", {31'b0, in_ready}, 32'd1);
        run_ones(8'd2, 8'd3);
        chk("arst_then_acc", {8'b0, out_acc}, 32'd24);
        take_result(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
